// File: rtl/lap_recall_buffer.sv
// lap_recall_buffer
// Lap memory and browser for the stopwatch datapath. Each rising edge of the
// lap button captures lap_value into a DEPTH-entry circular store. The next and
// prev buttons step the 1-based recall position forward or backward, acting on
// release after a press. The selected entry and its position feed the display.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-low reset
//   lap           lap button level; a rising edge stores lap_value
//   lap_value     current timer value (WIDTH bits)
//   next / prev   navigation button levels; act on release after a press
//   clear         synchronous clear of all stored laps (level)
//   save          entry at recall_index, 0 when empty
//   recall_index  1-based logical position (1 = oldest), 0 when empty
//   count         number of valid entries, 0..DEPTH
//   full / empty  count == DEPTH / count == 0
module lap_recall_buffer #(
  parameter int WIDTH         = 24,
  parameter int DEPTH         = 8,
  parameter bit OVERWRITE     = 1'b1,
  parameter bit FOLLOW_NEWEST = 1'b0,
  localparam int IW           = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lap,
  input  logic [WIDTH-1:0] lap_value,
  input  logic             next,
  input  logic             prev,
  input  logic             clear,
  output logic [WIDTH-1:0] save,
  output logic [IW-1:0]    recall_index,
  output logic [IW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            XW      = IW + 1;
  localparam logic [IW-1:0] DEPTH_C = IW'(DEPTH);
  localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH);
  localparam logic [PW-1:0] WP_LAST = PW'(DEPTH - 1);
  localparam logic [IW-1:0] ZERO_I  = IW'(0);
  localparam logic [IW-1:0] ONE_I   = IW'(1);
  localparam logic [PW-1:0] ZERO_P  = PW'(0);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wp_r;
  logic [IW-1:0]    count_r;
  logic [IW-1:0]    recall_index_r;
  logic             lap_q_r;
  logic             next_q_r;
  logic             prev_q_r;
  logic             armed_next_r;
  logic             armed_prev_r;
  logic             nav_ok_r;

  logic [PW-1:0]    wp_n_s;
  logic [IW-1:0]    count_n_s;
  logic [IW-1:0]    index_n_s;
  logic             armed_next_n_s;
  logic             armed_prev_n_s;

  logic             lap_act_s;
  logic             lap_accept_s;
  logic             next_rise_s;
  logic             next_fall_s;
  logic             prev_rise_s;
  logic             prev_fall_s;
  logic             next_act_s;
  logic             prev_act_s;
  logic             full_s;
  logic             empty_s;
  logic [XW-1:0]    slot_sum_s;
  logic [PW-1:0]    slot_s;

  // Button edge decode and lap acceptance
  always_comb begin
    lap_act_s    = lap & ~lap_q_r;
    // nav_ok_r masks the first cycle after reset, so a button already held
    // through reset is not mistaken for a fresh press and cannot arm.
    next_rise_s  = next & ~next_q_r & nav_ok_r;
    next_fall_s  = ~next & next_q_r;
    prev_rise_s  = prev & ~prev_q_r & nav_ok_r;
    prev_fall_s  = ~prev & prev_q_r;
    next_act_s   = next_fall_s & armed_next_r;
    prev_act_s   = prev_fall_s & armed_prev_r;
    full_s       = (count_r == DEPTH_C);
    empty_s      = (count_r == ZERO_I);
    lap_accept_s = lap_act_s & ~clear & (~full_s | OVERWRITE);
  end

  // Next-state for write pointer, occupancy, recall position and arming
  always_comb begin
    wp_n_s         = wp_r;
    count_n_s      = count_r;
    index_n_s      = recall_index_r;
    armed_next_n_s = armed_next_r;
    armed_prev_n_s = armed_prev_r;
    if (clear) begin
      wp_n_s         = ZERO_P;
      count_n_s      = ZERO_I;
      index_n_s      = ZERO_I;
      armed_next_n_s = 1'b0;
      armed_prev_n_s = 1'b0;
    end else begin
      if (next_rise_s) begin
        armed_next_n_s = 1'b1;
      end else if (next_fall_s) begin
        armed_next_n_s = 1'b0;
      end else begin
        armed_next_n_s = armed_next_r;
      end

      if (prev_rise_s) begin
        armed_prev_n_s = 1'b1;
      end else if (prev_fall_s) begin
        armed_prev_n_s = 1'b0;
      end else begin
        armed_prev_n_s = armed_prev_r;
      end

      // When full (overwrite allowed) slot wp holds the oldest entry, so the
      // same write/advance both appends the newest and drops the oldest.
      if (lap_accept_s) begin
        wp_n_s    = (wp_r == WP_LAST) ? ZERO_P : wp_r + ONE_P;
        count_n_s = full_s ? count_r : count_r + ONE_I;
      end else begin
        wp_n_s    = wp_r;
        count_n_s = count_r;
      end

      // Navigation wraps against the count held before any same-cycle lap.
      if (lap_accept_s && FOLLOW_NEWEST) begin
        index_n_s = count_n_s;
      end else if (lap_accept_s && empty_s) begin
        index_n_s = ONE_I;
      end else if (empty_s) begin
        index_n_s = recall_index_r;
      end else if (next_act_s && prev_act_s) begin
        index_n_s = recall_index_r;
      end else if (next_act_s) begin
        index_n_s = (recall_index_r == count_r) ? ONE_I : recall_index_r + ONE_I;
      end else if (prev_act_s) begin
        index_n_s = (recall_index_r == ONE_I) ? count_r : recall_index_r - ONE_I;
      end else begin
        index_n_s = recall_index_r;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_r           <= ZERO_P;
      count_r        <= ZERO_I;
      recall_index_r <= ZERO_I;
      lap_q_r        <= 1'b0;
      next_q_r       <= 1'b0;
      prev_q_r       <= 1'b0;
      armed_next_r   <= 1'b0;
      armed_prev_r   <= 1'b0;
      nav_ok_r       <= 1'b0;
    end else begin
      wp_r           <= wp_n_s;
      count_r        <= count_n_s;
      recall_index_r <= index_n_s;
      lap_q_r        <= lap;
      next_q_r       <= next;
      prev_q_r       <= prev;
      armed_next_r   <= armed_next_n_s;
      armed_prev_r   <= armed_prev_n_s;
      nav_ok_r       <= 1'b1;
    end
  end

  // Lap storage; a slot is only read once it has been counted as valid
  always_ff @(posedge clk) begin
    if (lap_accept_s) begin
      mem_r[wp_r] <= lap_value;
    end
  end

  // Logical-to-physical mapping: slot = (wp - count + index - 1) mod DEPTH.
  // The sum is biased by DEPTH to stay non-negative and is below 2*DEPTH,
  // so one conditional subtraction replaces the modulo.
  always_comb begin
    slot_sum_s = XW'(wp_r) + DEPTH_X - XW'(count_r) + XW'(recall_index_r) - XW'(1'b1);
    if (slot_sum_s >= DEPTH_X) begin
      slot_s = PW'(slot_sum_s - DEPTH_X);
    end else begin
      slot_s = PW'(slot_sum_s);
    end
  end

  // Display-side outputs, decoded from registered state
  always_comb begin
    save         = {WIDTH{1'b0}};
    recall_index = recall_index_r;
    count        = count_r;
    full         = full_s;
    empty        = empty_s;
    if (empty_s) begin
      save = {WIDTH{1'b0}};
    end else begin
      save = mem_r[slot_s];
    end
  end

endmodule

// File: doc/lap_recall_buffer.md
# lap_recall_buffer

Parametrised lap-memory and browser for the stopwatch datapath. Captures the running time value into a DEPTH-entry circular store on each lap press, and lets the user step forward or backward through stored laps with two buttons. The selected entry and its 1-based position go to the display mux. It replaces fixed eight-input recall selection: storage, occupancy tracking and bidirectional navigation now live in one block.

## Interface
- WIDTH, 24, bit width of one stored time value (BCD digits packed as in the timer core)
- DEPTH, 8, number of lap entries; any value ≥ 2
- OVERWRITE, 1, 1 = lap when full discards oldest entry; 0 = lap when full is ignored
- FOLLOW_NEWEST, 0, 1 = after every accepted lap, recall_index jumps to newest entry; 0 = index held
- IW (localparam) = $clog2(DEPTH+1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- lap  in  1  lap button level (synchronised, debounced upstream); action on rising edge
- lap_value  in  WIDTH  current timer value, sampled on lap action
- next  in  1  forward button level; action on release (see Operation)
- prev  in  1  backward button level; action on release
- clear  in  1  synchronous clear of all stored laps, level-sensitive, highest priority after rst
- save  out  WIDTH  value of entry at recall_index; 0 when empty
- recall_index  out  IW  1-based logical position (1 = oldest); 0 when empty
- count  out  IW  number of valid entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage: DEPTH×WIDTH registers, write pointer wp (0..DEPTH-1), count. Contents need not be reset; save is forced to 0 when empty.
- Edge detection: registered copies lap_q, next_q, prev_q, reset to 0. lap_act = lap & ~lap_q.
- Navigation buttons follow press/release arming: rising edge sets armed_x; falling edge while armed_x produces next_act/prev_act and clears armed_x. A falling edge without arming does nothing.
- Logical mapping: physical slot of index i (1..count) = (wp − count + i − 1) mod DEPTH.
- Lap accept:
  - count < DEPTH: write slot wp, wp ← wp+1 mod DEPTH, count ← count+1.
  - Full and OVERWRITE=1: write slot wp (the oldest), wp advances, count holds. The logical contents shift down by one, and recall_index is unchanged.
  - Full and OVERWRITE=0: ignored entirely.
- Index update, in priority order, evaluated per cycle:
  1. clear: count, wp, recall_index ← 0; armed flags ← 0.
  2. Accepted lap with FOLLOW_NEWEST=1: index ← new count. Any navigation action in the same cycle is discarded.
  3. Accepted lap into empty store: index ← 1.
  4. next_act & prev_act together: no index change (both disarm).
  5. next_act: index ← index+1, wrapping count→1.
  6. prev_act: index ← index−1, wrapping 1→count.
  - Navigation while empty is a no-op.
  - Navigation evaluates wrap against count before any same-cycle lap.
- save, full, empty and recall_index are combinational from registered state. There is no extra output register.

## Timing
- Reset (rst low, asynchronous): count=0, wp=0, recall_index=0, save=0, empty=1, full=0, all edge and armed registers 0.
- Lap: lap rises in the cycle before edge N, so lap_act is seen at edge N. lap_value is sampled at edge N. count, save and recall_index are valid after edge N, i.e. one cycle latency from the input rise.
- Navigation: one cycle from next/prev falling to the index update at the following edge. save follows in the same cycle.
- clear asserted for any cycle takes effect at the next edge. It overrides a lap or navigation in the same cycle; that lap is lost.
- rst deasserted mid-press (button held): no action until the button is released and pressed again, because armed=0 after reset.
- Holding lap high produces exactly one write.

## Test plan
- Reset, then 3 laps with values 0x000101, 0x000202, 0x000303 → count=3, index=1, save=0x000101. Three next releases → index 2, 3, 1.
- Store empty, press and release next and prev → index stays 0, save=0.
- DEPTH=8, OVERWRITE=1: 10 laps with values 1..10, index held at 1 → full=1, count=8, save=3. prev → index 8, save=10.
- OVERWRITE=0, full with values 1..8, a 9th lap of 99 → count=8, no entry equals 99, wp unchanged.
- FOLLOW_NEWEST=1: a lap in the same cycle as a next release, with count=2 and index=1 → count=3, index=3.
- Next and prev released in the same cycle → index unchanged. clear together with lap → count=0, empty=1. rst pulsed while next is held, then next released → no index change.
